// File: rtl/regfile_gen_pkg.sv
// regfile_gen_pkg: shared dump FSM state type and default geometry for the register file
package regfile_gen_pkg;
    localparam int DEF_DATA_W = 24;
    localparam int DEF_ADDR_W = 4;
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } dump_state_e;
endpackage

// File: rtl/regfile_gen_if.sv
// regfile_gen_if: register file bus (write port, packed read ports, wp_err, dump stream, busy)
//   master drives we/waddr/wdata/raddr/dump_start/dump_ready, slave drives the rest
interface regfile_gen_if
    import regfile_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NRD    = 2
);
    logic                    we;
    logic [ADDR_W-1:0]       waddr;
    logic [DATA_W-1:0]       wdata;
    logic [NRD*ADDR_W-1:0]   raddr;
    logic [NRD*DATA_W-1:0]   rdata;
    logic                    wp_err;
    logic                    dump_start;
    logic                    dump_valid;
    logic                    dump_ready;
    logic [ADDR_W-1:0]       dump_addr;
    logic [DATA_W-1:0]       dump_data;
    logic                    dump_last;
    logic                    busy;
    modport master (
        output we, waddr, wdata, raddr, dump_start, dump_ready,
        input  rdata, wp_err, dump_valid, dump_addr, dump_data, dump_last, busy
    );
    modport slave (
        input  we, waddr, wdata, raddr, dump_start, dump_ready,
        output rdata, wp_err, dump_valid, dump_addr, dump_data, dump_last, busy
    );
endinterface

// File: rtl/regfile_dump_seq.sv
// regfile_dump_seq: dump engine streaming every register once, ascending, with valid/ready
//   start_i/ready_i: request and beat acceptance; ld_data_i: register at idx_o
//   valid_o/addr_o/data_o/last_o: held beat; busy_o: engine not IDLE
module regfile_dump_seq
    import regfile_gen_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output logic              busy_o
);
    dump_state_e       state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic              last_q;
    logic              busy_q;

    // the beat is captured on the LOAD edge, so a same-edge write is not seen
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    state_q <= LOAD;
                    busy_q  <= 1'b1;
                end
                LOAD: begin
                    data_q  <= ld_data_i;
                    addr_q  <= idx_q;
                    last_q  <= &idx_q;
                    valid_q <= 1'b1;
                    state_q <= SEND;
                end
                SEND: if (ready_i) begin
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                    if (&idx_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                    end else begin
                        idx_q   <= idx_q + ADDR_W'(1);
                        state_q <= LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign idx_o   = idx_q;
    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign busy_o  = busy_q;
endmodule

// File: rtl/regfile_gen.sv
// regfile_gen: parameterised register bank with write protection, forwarding reads and a dump stream
//   clk/rst_n: clock and synchronous active-low reset; bus: regfile_gen_if slave
module regfile_gen
    import regfile_gen_pkg::*;
#(
    parameter int                               DATA_W   = DEF_DATA_W,
    parameter int                               ADDR_W   = DEF_ADDR_W,
    parameter int                               NRD      = 2,
    parameter logic [(2**ADDR_W)*DATA_W-1:0]    RST_INIT = '0,
    parameter logic [(2**ADDR_W)-1:0]           WP_MASK  = '0,
    parameter bit                               BYPASS   = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    regfile_gen_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic                  wp_err_q;
    logic                  wr_ok;
    logic [NRD*DATA_W-1:0] rd_mux;
    logic [ADDR_W-1:0]     dump_idx;

    // writes are suppressed while reset is asserted, which also disables forwarding
    assign wr_ok = rst_n && bus.we && !WP_MASK[bus.waddr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_INIT[i*DATA_W +: DATA_W];
        end else if (wr_ok) begin
            mem_q[bus.waddr] <= bus.wdata;
        end
        wp_err_q <= rst_n && bus.we && WP_MASK[bus.waddr];
    end

    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_mux[k*DATA_W +: DATA_W] =
                (BYPASS && wr_ok && bus.waddr == bus.raddr[k*ADDR_W +: ADDR_W]) ?
                bus.wdata : mem_q[bus.raddr[k*ADDR_W +: ADDR_W]];
        end
    end

    assign bus.rdata  = rd_mux;
    assign bus.wp_err = wp_err_q;

    regfile_dump_seq #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_dump (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (bus.dump_start),
        .ready_i   (bus.dump_ready),
        .ld_data_i (mem_q[dump_idx]),
        .idx_o     (dump_idx),
        .valid_o   (bus.dump_valid),
        .addr_o    (bus.dump_addr),
        .data_o    (bus.dump_data),
        .last_o    (bus.dump_last),
        .busy_o    (bus.busy)
    );
endmodule

// File: tb/tb_regfile_gen.sv
// tb_regfile_gen: directed self-checking bench for regfile_gen
module tb_regfile_gen;
    localparam logic [16*24-1:0] INIT = {{12{24'h000000}}, 24'h333333, 24'h000000, 24'h40C020, 24'h900110};

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   beat;
    int   cyc;
    logic [23:0] exp_mem [16];
    logic [23:0] rd0, rd1;

    regfile_gen_if #(.DATA_W(24), .ADDR_W(4), .NRD(2)) bus ();

    regfile_gen #(
        .DATA_W   (24),
        .ADDR_W   (4),
        .NRD      (2),
        .RST_INIT (INIT),
        .WP_MASK  (16'h0008),
        .BYPASS   (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign rd0 = bus.rdata[23:0];
    assign rd1 = bus.rdata[47:24];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ra(input logic [3:0] a0, input logic [3:0] a1);
        bus.raddr = {a1, a0};
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [23:0] d);
        bus.we = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
        tick();
        bus.we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) exp_mem[i] = 24'h0;
        exp_mem[0] = 24'h900110;
        exp_mem[1] = 24'h40C020;
        exp_mem[3] = 24'h333333;
        rst_n = 1'b0;
        bus.we = 1'b0;
        bus.waddr = '0;
        bus.wdata = '0;
        bus.raddr = '0;
        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        ra(4'd0, 4'd1);
        chk("rst_rd0", rd0, 24'h900110);
        chk("rst_rd1", rd1, 24'h40C020);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_valid", bus.dump_valid, 1'b0);
        chk("rst_wp_err", bus.wp_err, 1'b0);
        chk("rst_daddr", bus.dump_addr, 4'd0);
        chk("rst_ddata", bus.dump_data, 24'h0);
        // forwarding of an unprotected write
        bus.we = 1'b1;
        bus.waddr = 4'd5;
        bus.wdata = 24'hABCDEF;
        ra(4'd5, 4'd4);
        chk("byp_rd0", rd0, 24'hABCDEF);
        chk("byp_rd1", rd1, 24'h000000);
        tick();
        bus.we = 1'b0;
        exp_mem[5] = 24'hABCDEF;
        #1;
        chk("byp_persist", rd0, 24'hABCDEF);
        // protected write: no forwarding, dropped, one-cycle wp_err
        bus.we = 1'b1;
        bus.waddr = 4'd3;
        bus.wdata = 24'h123456;
        ra(4'd3, 4'd5);
        chk("wp_nobyp", rd0, 24'h333333);
        chk("wp_err_pre", bus.wp_err, 1'b0);
        tick();
        bus.we = 1'b0;
        #1;
        chk("wp_err_pulse", bus.wp_err, 1'b1);
        chk("wp_hold", rd0, 24'h333333);
        tick();
        chk("wp_err_clear", bus.wp_err, 1'b0);
        wr(4'd2, 24'h000222);
        wr(4'd9, 24'h123ABC);
        wr(4'd15, 24'hF0F0F0);
        exp_mem[2] = 24'h000222;
        exp_mem[9] = 24'h123ABC;
        exp_mem[15] = 24'hF0F0F0;
        ra(4'd9, 4'd15);
        chk("wr_rd9", rd0, 24'h123ABC);
        chk("wr_rd15", rd1, 24'hF0F0F0);
        // full dump, consumer always ready
        bus.dump_ready = 1'b1;
        bus.dump_start = 1'b1;
        beat = 0;
        cyc = 0;
        while (beat < 16 && cyc < 80) begin
            tick();
            cyc++;
            bus.dump_start = 1'b0;
            if (bus.dump_valid) begin
                chk("d1_addr", 32'(bus.dump_addr), 32'(beat));
                chk("d1_data", bus.dump_data, exp_mem[beat]);
                chk("d1_last", bus.dump_last, beat == 15);
                chk("d1_busy", bus.busy, 1'b1);
                beat++;
            end
        end
        chk("d1_beats", 32'(beat), 32'd16);
        chk("d1_cycles", 32'(cyc), 32'd32);
        tick();
        chk("d1_busy_end", bus.busy, 1'b0);
        chk("d1_valid_end", bus.dump_valid, 1'b0);
        // dump with a stall on beat 2, then reset on beat 7
        bus.dump_start = 1'b1;
        beat = 0;
        cyc = 0;
        while (beat < 16 && cyc < 120) begin
            tick();
            cyc++;
            bus.dump_start = 1'b0;
            if (bus.dump_valid) begin
                chk("d2_addr", 32'(bus.dump_addr), 32'(beat));
                chk("d2_data", bus.dump_data, exp_mem[beat]);
                if (beat == 7) break;
                if (beat == 2) begin
                    bus.dump_ready = 1'b0;
                    bus.we = 1'b1;
                    bus.waddr = 4'd2;
                    bus.wdata = 24'h000777;
                    repeat (5) begin
                        tick();
                        bus.we = 1'b0;
                        chk("stall_valid", bus.dump_valid, 1'b1);
                        chk("stall_addr", bus.dump_addr, 4'd2);
                        chk("stall_data", bus.dump_data, 24'h000222);
                        chk("stall_last", bus.dump_last, 1'b0);
                    end
                    exp_mem[2] = 24'h000777;
                    bus.dump_ready = 1'b1;
                end
                beat++;
            end
        end
        chk("d2_reach7", 32'(beat), 32'd7);
        rst_n = 1'b0;
        bus.we = 1'b1;
        bus.waddr = 4'd6;
        bus.wdata = 24'hDEAD01;
        ra(4'd2, 4'd6);
        chk("prerst_rd2", rd0, 24'h000777);
        chk("prerst_nobyp", rd1, 24'h000000);
        tick();
        rst_n = 1'b1;
        bus.we = 1'b0;
        #1;
        chk("abort_valid", bus.dump_valid, 1'b0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_last", bus.dump_last, 1'b0);
        chk("abort_addr", bus.dump_addr, 4'd0);
        chk("post_rd2", rd0, 24'h000000);
        chk("post_rd6", rd1, 24'h000000);
        ra(4'd0, 4'd1);
        chk("post_rd0", rd0, 24'h900110);
        chk("post_rd1", rd1, 24'h40C020);
        ra(4'd3, 4'd5);
        chk("post_rd3", rd0, 24'h333333);
        chk("post_rd5", rd1, 24'h000000);
        tick();
        chk("post_idle", bus.busy, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
